// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, burst-locking arbiter for the single write
// port of an async FIFO. One requester owns the port from grant until its
// last beat (or MAX_BURST beats), so packets never interleave in the FIFO.
// There is one arbitration cycle before each burst and no transfer in it.

module fifo_wr_arbiter #(
  parameter int NREQ       = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 8
) (
  input  logic                       wclk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ-1:0]            req_last,
  input  logic [NREQ*DATA_WIDTH-1:0] req_data,
  output logic [NREQ-1:0]            req_ready,
  input  logic                       full,
  output logic                       winc,
  output logic [DATA_WIDTH-1:0]      wdata,
  output logic [NREQ-1:0]            grant,
  output logic                       busy
);

  localparam int PTR_W = $clog2(NREQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t              state_r;
  state_t              state_n_s;
  logic [PTR_W-1:0]    rr_ptr_r;
  logic [PTR_W-1:0]    rr_ptr_n_s;
  logic [CNT_W-1:0]    beat_cnt_r;
  logic [CNT_W-1:0]    beat_cnt_n_s;
  logic [NREQ-1:0]     grant_n_s;

  logic [PTR_W-1:0]    owner_s;
  logic [PTR_W-1:0]    pick_idx_s;
  logic                pick_found_s;
  logic                burst_end_s;

  // Owner index decoded from the one-hot registered grant.
  always_comb begin
    owner_s = {PTR_W{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      owner_s = grant[i] ? PTR_W'(i) : owner_s;
    end
  end

  // First valid requester scanning from rr_ptr upward, wrapping modulo NREQ.
  always_comb begin
    logic [PTR_W-1:0] idx_v;
    idx_v        = {PTR_W{1'b0}};
    pick_idx_s   = {PTR_W{1'b0}};
    pick_found_s = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx_v        = PTR_W'((int'(rr_ptr_r) + k) % NREQ);
      pick_idx_s   = (req_valid[idx_v] && !pick_found_s) ? idx_v : pick_idx_s;
      pick_found_s = pick_found_s | req_valid[idx_v];
    end
  end

  // Write-port outputs: only the locked owner reaches the FIFO; full gates
  // winc and ready with a single AND so the full->winc path stays short.
  always_comb begin
    winc      = 1'b0;
    req_ready = {NREQ{1'b0}};
    wdata     = {DATA_WIDTH{1'b0}};
    busy      = 1'b0;
    if (state_r == LOCKED) begin
      busy               = 1'b1;
      req_ready[owner_s] = ~full;
      winc               = req_valid[owner_s] & ~full;
      wdata              = req_data[owner_s*DATA_WIDTH +: DATA_WIDTH];
    end else begin
      busy = 1'b0;
    end
  end

  // A burst ends on a transferred beat that is either the packet's last
  // beat or the MAX_BURST-th beat of this grant (truncation).
  always_comb begin
    burst_end_s = winc & (req_last[owner_s] |
                          (beat_cnt_r == CNT_W'(MAX_BURST - 1)));
  end

  // Next-state logic for the IDLE/LOCKED FSM, grant, pointer and beat count.
  always_comb begin
    state_n_s    = state_r;
    grant_n_s    = grant;
    rr_ptr_n_s   = rr_ptr_r;
    beat_cnt_n_s = beat_cnt_r;
    case (state_r)
      IDLE: begin
        if (pick_found_s) begin
          state_n_s    = LOCKED;
          grant_n_s    = {{(NREQ-1){1'b0}}, 1'b1} << pick_idx_s;
          beat_cnt_n_s = {CNT_W{1'b0}};
        end else begin
          state_n_s = IDLE;
        end
      end
      LOCKED: begin
        if (burst_end_s) begin
          state_n_s    = IDLE;
          grant_n_s    = {NREQ{1'b0}};
          beat_cnt_n_s = {CNT_W{1'b0}};
          rr_ptr_n_s   = (owner_s == PTR_W'(NREQ - 1)) ? {PTR_W{1'b0}}
                                                       : owner_s + PTR_W'(1);
        end else if (winc) begin
          beat_cnt_n_s = beat_cnt_r + CNT_W'(1);
        end else begin
          beat_cnt_n_s = beat_cnt_r;
        end
      end
      default: begin
        state_n_s    = IDLE;
        grant_n_s    = {NREQ{1'b0}};
        beat_cnt_n_s = {CNT_W{1'b0}};
        rr_ptr_n_s   = {PTR_W{1'b0}};
      end
    endcase
  end

  // State registers; reset abandons any burst in progress.
  always_ff @(posedge wclk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      grant      <= {NREQ{1'b0}};
      rr_ptr_r   <= {PTR_W{1'b0}};
      beat_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r    <= state_n_s;
      grant      <= grant_n_s;
      rr_ptr_r   <= rr_ptr_n_s;
      beat_cnt_r <= beat_cnt_n_s;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter (NREQ=4, DATA_WIDTH=8, MAX_BURST=8):
// a vector table for reset, rotation and backpressure, then hand-written
// sequences for packet lock, full stalls, truncation and mid-burst reset.

module tb_fifo_wr_arbiter;

  logic        wclk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_last;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        full;
  logic        winc;
  logic [7:0]  wdata;
  logic [3:0]  grant;
  logic        busy;

  int total;
  int bad;

  fifo_wr_arbiter #(.NREQ(4), .DATA_WIDTH(8), .MAX_BURST(8)) dut (
    .wclk      (wclk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_data  (req_data),
    .req_ready (req_ready),
    .full      (full),
    .winc      (winc),
    .wdata     (wdata),
    .grant     (grant),
    .busy      (busy)
  );

  // 10-time-unit write clock.
  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  typedef struct packed {
    logic       rst_n;
    logic [3:0] valid;
    logic [3:0] last;
    logic       full;
    logic [3:0] e_grant;
    logic       e_busy;
    logic       e_winc;
    logic [3:0] e_ready;
    logic [7:0] e_wdata;
  } vec_t;

  vec_t vecs [0:19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = 4'b0000;
    req_last  = 4'b0000;
    full      = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int beat;
    int wr;
    int sent0;
    logic [7:0] exp_q [0:10];

    total = 0;
    bad   = 0;

    // rst, valid, last, full | grant, busy, winc, ready, wdata
    vecs[0]  = {1'b0, 4'hF, 4'hF, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 8'h00};
    vecs[1]  = {1'b0, 4'hF, 4'hF, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 8'h00};
    vecs[2]  = {1'b1, 4'hF, 4'hF, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 8'h00};
    vecs[3]  = {1'b1, 4'hF, 4'hF, 1'b0, 4'h1, 1'b1, 1'b1, 4'h1, 8'hA0};
    vecs[4]  = {1'b1, 4'hF, 4'hF, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 8'h00};
    vecs[5]  = {1'b1, 4'hF, 4'hF, 1'b0, 4'h2, 1'b1, 1'b1, 4'h2, 8'hA1};
    vecs[6]  = {1'b1, 4'hF, 4'hF, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 8'h00};
    vecs[7]  = {1'b1, 4'hF, 4'hF, 1'b0, 4'h4, 1'b1, 1'b1, 4'h4, 8'hA2};
    vecs[8]  = {1'b1, 4'hF, 4'hF, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 8'h00};
    vecs[9]  = {1'b1, 4'hF, 4'hF, 1'b0, 4'h8, 1'b1, 1'b1, 4'h8, 8'hA3};
    vecs[10] = {1'b1, 4'hF, 4'hF, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 8'h00};
    vecs[11] = {1'b1, 4'hF, 4'hF, 1'b0, 4'h1, 1'b1, 1'b1, 4'h1, 8'hA0};
    vecs[12] = {1'b1, 4'hF, 4'hF, 1'b1, 4'h0, 1'b0, 1'b0, 4'h0, 8'h00};
    vecs[13] = {1'b1, 4'hF, 4'hF, 1'b1, 4'h2, 1'b1, 1'b0, 4'h0, 8'hA1};
    vecs[14] = {1'b1, 4'h1, 4'h0, 1'b0, 4'h2, 1'b1, 1'b0, 4'h2, 8'hA1};
    vecs[15] = {1'b1, 4'hF, 4'h2, 1'b0, 4'h2, 1'b1, 1'b1, 4'h2, 8'hA1};
    vecs[16] = {1'b1, 4'h1, 4'h1, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 8'h00};
    vecs[17] = {1'b1, 4'h1, 4'h1, 1'b0, 4'h1, 1'b1, 1'b1, 4'h1, 8'hA0};
    vecs[18] = {1'b1, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 8'h00};
    vecs[19] = {1'b1, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 8'h00};

    // First reset edge (table rows 0 and 1 supply the next two).
    rst_n     = 1'b0;
    req_valid = 4'hF;
    req_last  = 4'hF;
    full      = 1'b0;
    req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    tick();

    for (int i = 0; i < 20; i++) begin
      rst_n     = vecs[i].rst_n;
      req_valid = vecs[i].valid;
      req_last  = vecs[i].last;
      full      = vecs[i].full;
      @(negedge wclk);
      chk($sformatf("vec%0d_grant", i), grant,     vecs[i].e_grant);
      chk($sformatf("vec%0d_busy",  i), busy,      vecs[i].e_busy);
      chk($sformatf("vec%0d_winc",  i), winc,      vecs[i].e_winc);
      chk($sformatf("vec%0d_ready", i), req_ready, vecs[i].e_ready);
      chk($sformatf("vec%0d_wdata", i), wdata,     vecs[i].e_wdata);
      tick();
    end

    // Packet lock: move rr_ptr to 2, then requester 2 sends 3 beats while
    // requester 0 stays valid; requester 0 must wait for the whole packet.
    do_reset();
    req_valid = 4'b0010;
    req_last  = 4'b0010;
    tick();
    tick();
    req_valid = 4'b0101;
    req_last  = 4'b0000;
    req_data[23:16] = 8'hC0;
    tick();
    for (int b = 0; b < 3; b++) begin
      req_last        = (b == 2) ? 4'b0101 : 4'b0001;
      req_data[23:16] = 8'(8'hC0 + b);
      @(negedge wclk);
      chk($sformatf("lock_grant%0d", b), grant, 4'h4);
      chk($sformatf("lock_winc%0d", b), winc, 1'b1);
      chk($sformatf("lock_wdata%0d", b), wdata, 8'(8'hC0 + b));
      chk($sformatf("lock_ready%0d", b), req_ready, 4'h4);
      tick();
    end
    req_valid = 4'b0001;
    @(negedge wclk);
    chk("lock_idle_grant", grant, 4'h0);
    chk("lock_idle_winc", winc, 1'b0);
    chk("lock_rr_ptr", dut.rr_ptr_r, 2'd3);
    tick();
    @(negedge wclk);
    chk("lock_next_grant", grant, 4'h1);
    tick();

    // Full backpressure: requester 1 sends B0..B4, full high for 4 cycles
    // after two beats.
    do_reset();
    beat = 0;
    wr   = 0;
    for (int c = 0; c < 16; c++) begin
      full           = (c >= 3 && c <= 6);
      req_valid      = (beat < 5) ? 4'b0010 : 4'b0000;
      req_last       = (beat == 4) ? 4'b0010 : 4'b0000;
      req_data[15:8] = 8'(8'hB0 + beat);
      @(negedge wclk);
      if (c >= 3 && c <= 6) begin
        chk($sformatf("full_winc_c%0d", c), winc, 1'b0);
        chk($sformatf("full_ready_c%0d", c), req_ready[1], 1'b0);
        chk($sformatf("full_grant_c%0d", c), grant, 4'h2);
        chk($sformatf("full_cnt_c%0d", c), dut.beat_cnt_r, 32'd2);
      end
      if (winc === 1'b1) begin
        chk($sformatf("full_wdata%0d", wr), wdata, 8'(8'hB0 + wr));
        wr++;
      end
      if (req_valid[1] && req_ready[1] === 1'b1) beat++;
      tick();
    end
    full = 1'b0;
    chk("full_write_count", wr, 5);
    chk("full_end_grant", grant, 4'h0);

    // MAX_BURST truncation: requester 3 sends 10 beats; requester 0 (one
    // single-beat packet) is served between the two halves.
    for (int i = 0; i < 8; i++) exp_q[i] = 8'(8'hD0 + i);
    exp_q[8]  = 8'h55;
    exp_q[9]  = 8'hD8;
    exp_q[10] = 8'hD9;
    do_reset();
    beat  = 0;
    sent0 = 0;
    wr    = 0;
    for (int c = 0; c < 24; c++) begin
      req_valid        = 4'b0000;
      req_last         = 4'b0000;
      req_valid[3]     = (beat < 10);
      req_last[3]      = (beat == 9);
      req_data[31:24]  = 8'(8'hD0 + beat);
      req_valid[0]     = (c >= 1) && (sent0 == 0);
      req_last[0]      = 1'b1;
      req_data[7:0]    = 8'h55;
      @(negedge wclk);
      if (winc === 1'b1) begin
        if (wr < 11) chk($sformatf("mb_wdata%0d", wr), wdata, exp_q[wr]);
        else chk("mb_extra_write", wr, 11);
        wr++;
      end
      if (req_valid[3] && req_ready[3] === 1'b1) beat++;
      if (req_valid[0] && req_ready[0] === 1'b1) sent0 = 1;
      tick();
    end
    chk("mb_write_count", wr, 11);

    // Reset mid-burst: rr_ptr moved to 2, requester 2 starts 5 beats, reset
    // after beat 2; next arbitration must start from rr_ptr 0.
    do_reset();
    req_valid = 4'b0010;
    req_last  = 4'b0010;
    tick();
    tick();
    req_valid = 4'b0100;
    req_last  = 4'b0000;
    tick();
    for (int b = 0; b < 2; b++) begin
      @(negedge wclk);
      chk($sformatf("mrst_beat%0d_winc", b), winc, 1'b1);
      tick();
    end
    rst_n = 1'b0;
    tick();
    rst_n     = 1'b1;
    req_valid = 4'b0110;
    @(negedge wclk);
    chk("mrst_grant", grant, 4'h0);
    chk("mrst_winc", winc, 1'b0);
    chk("mrst_busy", busy, 1'b0);
    tick();
    @(negedge wclk);
    chk("mrst_rearb_grant", grant, 4'h2);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
